multi_sync_debounce: RTL and testbench

MULTI_SYNC_DEBOUNCE -- requirements
Module: multi_sync_debounce

---
 rtl/multi_sync_debounce_pkg.sv | 23 ++
 rtl/sync_debounce_channel.sv | 70 +++++++
 rtl/multi_sync_debounce.sv | 55 +++++
 tb/tb_multi_sync_debounce.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multi_sync_debounce_pkg.sv
// Shared defaults, legal parameter ranges and the effective-limit rule for
// the multi-channel synchroniser/debouncer.
package multi_sync_debounce_pkg;

  localparam int unsigned CHANNELS_DEF   = 4;
  localparam int unsigned CHANNELS_MIN   = 1;
  localparam int unsigned CHANNELS_MAX   = 32;
  localparam int unsigned SYNC_STAGE_DEF = 2;
  localparam int unsigned SYNC_STAGE_MIN = 2;
  localparam int unsigned SYNC_STAGE_MAX = 4;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam logic        INIT_SIGNAL_DEF = 1'b1;

  // A debounce_limit of zero behaves as a one-cycle window.
  localparam int unsigned MIN_EFF_LIMIT  = 1;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_e;

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel: synchroniser chain, stability counter, debounced level and
// registered rise/fall pulses.
module sync_debounce_channel
  import multi_sync_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGE  = SYNC_STAGE_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter logic        INIT_SIGNAL = INIT_SIGNAL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal_i,
  input  logic [CNT_W-1:0] debounce_limit_i,
  output logic             syn_signal_o,
  output logic             rise_pulse_o,
  output logic             fall_pulse_o,
  output logic             rise_next_o,
  output logic             fall_next_o
);

  logic [SYNC_STAGE-1:0] sync_q;
  logic                  level_q, level_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rise_q, fall_q;
  logic                  sync_out;
  logic [CNT_W-1:0]      eff_limit;
  logic [CNT_W:0]        cnt_inc;
  edge_e                 edge_d;

  // Increment is computed one bit wider so the compare cannot see a wrap.
  always_comb begin
    sync_out  = sync_q[SYNC_STAGE-1];
    eff_limit = (debounce_limit_i == '0) ? CNT_W'(MIN_EFF_LIMIT) : debounce_limit_i;
    cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    level_d   = level_q;
    cnt_d     = '0;
    edge_d    = EDGE_NONE;
    if (sync_out != level_q) begin
      if (cnt_inc >= {1'b0, eff_limit}) begin
        level_d = sync_out;
        edge_d  = sync_out ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGE{INIT_SIGNAL}};
      level_q <= INIT_SIGNAL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGE-2:0], signal_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= (edge_d == EDGE_RISE);
      fall_q  <= (edge_d == EDGE_FALL);
    end
  end

  assign syn_signal_o = level_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
  assign rise_next_o  = (edge_d == EDGE_RISE);
  assign fall_next_o  = (edge_d == EDGE_FALL);

endmodule

// File: rtl/multi_sync_debounce.sv
// Bank of independent synchronise-and-debounce channels with a registered
// any-change flag aligned to the per-channel pulses.
module multi_sync_debounce
  import multi_sync_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS    = CHANNELS_DEF,
  parameter int unsigned SYNC_STAGE  = SYNC_STAGE_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter logic        INIT_SIGNAL = INIT_SIGNAL_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal,
  input  logic [CNT_W-1:0]    debounce_limit,
  output logic [CHANNELS-1:0] syn_signal,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
      SYNC_STAGE < SYNC_STAGE_MIN || SYNC_STAGE > SYNC_STAGE_MAX) begin : g_bad_param
    $error("multi_sync_debounce: CHANNELS or SYNC_STAGE out of range");
  end

  logic [CHANNELS-1:0] rise_next, fall_next;
  logic                any_change_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    sync_debounce_channel #(
      .SYNC_STAGE (SYNC_STAGE),
      .CNT_W      (CNT_W),
      .INIT_SIGNAL(INIT_SIGNAL)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .signal_i        (signal[g]),
      .debounce_limit_i(debounce_limit),
      .syn_signal_o    (syn_signal[g]),
      .rise_pulse_o    (rise_pulse[g]),
      .fall_pulse_o    (fall_pulse[g]),
      .rise_next_o     (rise_next[g]),
      .fall_next_o     (fall_next[g])
    );
  end

  // Built from next-state pulses so it lands in the same cycle as them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_change_q <= 1'b0;
    else       any_change_q <= |(rise_next | fall_next);
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Scoreboard bench: stimulus queues expected pulse events, a monitor checks
// every cycle in which the DUT reports a change.
module tb_multi_sync_debounce;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  signal;
  logic [15:0] debounce_limit;
  logic [3:0]  syn_signal, rise_pulse, fall_pulse;
  logic        any_change;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int         at;
    logic [3:0] syn;
    logic [3:0] rise;
    logic [3:0] fall;
  } ev_t;

  ev_t q[$];

  multi_sync_debounce #(
    .CHANNELS   (4),
    .SYNC_STAGE (2),
    .CNT_W      (16),
    .INIT_SIGNAL(1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .signal        (signal),
    .debounce_limit(debounce_limit),
    .syn_signal    (syn_signal),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .any_change    (any_change)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int at, input logic [3:0] s, input logic [3:0] r,
                           input logic [3:0] f);
    ev_t e;
    e.at = at; e.syn = s; e.rise = r; e.fall = f;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].at < cyc) begin
        chk("missed_event_cycle", 32'(cyc), 32'(q[0].at));
        void'(q.pop_front());
      end
      if (any_change || (rise_pulse != 4'h0) || (fall_pulse != 4'h0)) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {any_change, rise_pulse, fall_pulse}, 32'h0);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("ev_cycle", 32'(cyc), 32'(e.at));
          chk("ev_syn", 32'(syn_signal), 32'(e.syn));
          chk("ev_rise", 32'(rise_pulse), 32'(e.rise));
          chk("ev_fall", 32'(fall_pulse), 32'(e.fall));
          chk("ev_any", 32'(any_change), 32'd1);
          chk("ev_rise_and_fall", 32'(rise_pulse & fall_pulse), 32'h0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    reset = 1'b1;
    signal = 4'hF;
    debounce_limit = 16'd4;
    repeat (3) @(negedge clk);
    chk("rst_syn", 32'(syn_signal), 32'hF);
    chk("rst_rise", 32'(rise_pulse), 32'h0);
    chk("rst_fall", 32'(fall_pulse), 32'h0);
    chk("rst_any", 32'(any_change), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_syn", 32'(syn_signal), 32'hF);

    // channel 0 falls with L=4: update at edge 6
    expect_ev(cyc + 6, 4'hE, 4'h0, 4'h1);
    signal[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("ch0_before_window", 32'(syn_signal), 32'hF);
    repeat (5) @(negedge clk);
    chk("ch0_after_fall", 32'(syn_signal), 32'hE);

    // 3-cycle glitch on channel 1 is rejected
    signal[1] = 1'b0;
    repeat (3) @(negedge clk);
    signal[1] = 1'b1;
    repeat (10) @(negedge clk);
    chk("ch1_glitch_rejected", 32'(syn_signal), 32'hE);

    expect_ev(cyc + 6, 4'hF, 4'h1, 4'h0);
    signal[0] = 1'b1;
    repeat (10) @(negedge clk);

    // limit 0 acts as L=1: update at edge 3
    debounce_limit = 16'd0;
    expect_ev(cyc + 3, 4'hB, 4'h0, 4'h4);
    signal[2] = 1'b0;
    repeat (6) @(negedge clk);
    expect_ev(cyc + 3, 4'hF, 4'h4, 4'h0);
    signal[2] = 1'b1;
    repeat (6) @(negedge clk);
    chk("ch2_restored", 32'(syn_signal), 32'hF);

    // limit 100, lowered to 10 once the count reaches 50
    debounce_limit = 16'd100;
    m = cyc;
    expect_ev(m + 53, 4'h7, 4'h0, 4'h8);
    signal[3] = 1'b0;
    repeat (52) @(negedge clk);
    chk("ch3_mid_count", 32'(syn_signal), 32'hF);
    debounce_limit = 16'd10;
    repeat (3) @(negedge clk);
    chk("ch3_after_limit_drop", 32'(syn_signal), 32'h7);
    debounce_limit = 16'd4;
    expect_ev(cyc + 6, 4'hF, 4'h8, 4'h0);
    signal[3] = 1'b1;
    repeat (10) @(negedge clk);

    // all channels together
    expect_ev(cyc + 6, 4'h0, 4'h0, 4'hF);
    signal = 4'h0;
    repeat (10) @(negedge clk);
    chk("all_low", 32'(syn_signal), 32'h0);
    expect_ev(cyc + 6, 4'hF, 4'hF, 4'h0);
    signal = 4'hF;
    repeat (10) @(negedge clk);

    // reset mid-count discards progress
    signal = 4'h0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_syn", 32'(syn_signal), 32'hF);
    chk("midrst_pulses", 32'({rise_pulse, fall_pulse, 3'b000, any_change}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    expect_ev(cyc + 6, 4'h0, 4'h0, 4'hF);
    repeat (5) @(negedge clk);
    chk("midrst_full_window", 32'(syn_signal), 32'hF);
    repeat (5) @(negedge clk);
    chk("midrst_final", 32'(syn_signal), 32'h0);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
